// File: rtl/morph_filter.sv
// -----------------------------------------------------------------------------
// morph_filter
//   Binary erode/dilate stage for a raster video stream, square KSIZE x KSIZE
//   kernel (3 or 5). Owns its line buffers, column/row counters and border
//   padding. Fixed 3-clk latency on data and syncs regardless of KSIZE.
//
//   Build option:
//     MORPH_FG_COUNT_EN - adds fg_count / fg_count_vld, a per-frame count of
//                         foreground output pixels latched on the dout_vsync
//                         rising edge.
//
//   The output pixel for input position (col,row) reduces the window whose
//   bottom-right tap is (col,row). The output is therefore shifted by
//   (KSIZE-1)/2 pixels right and down relative to a centred kernel; the
//   downstream path accounts for that.
// -----------------------------------------------------------------------------
module morph_filter #(
  parameter int H_DISP = 640,
  parameter int V_DISP = 480,
  parameter int KSIZE  = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       mode,
  input  logic       din_de,
  input  logic       din_hsync,
  input  logic       din_vsync,
  input  logic [7:0] din_data,
  output logic       dout_de,
  output logic       dout_hsync,
  output logic       dout_vsync,
  output logic [7:0] dout_data
`ifdef MORPH_FG_COUNT_EN
  ,
  output logic [$clog2(H_DISP*V_DISP+1)-1:0] fg_count,
  output logic                               fg_count_vld
`endif
);

  localparam int CW  = (H_DISP > 1) ? $clog2(H_DISP) : 1;
  localparam int RW  = (V_DISP > 1) ? $clog2(V_DISP) : 1;
  localparam int NLB = KSIZE - 1;

  // Only 3x3 and 5x5 kernels are supported.
  generate
    if (KSIZE != 3 && KSIZE != 5) begin : g_ksize_check
      $error("morph_filter: KSIZE must be 3 or 5");
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Frame start and mode capture
  // ---------------------------------------------------------------------------
  logic vsync_d_reg;
  logic mode_reg;
  logic frame_start;
  logic pix_in;

  assign frame_start = din_vsync & ~vsync_d_reg;
  assign pix_in      = |din_data;

  // Detect the vsync rising edge; mode is only taken on that edge so a
  // mid-frame change waits for the next frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_d_reg <= 1'b0;
      mode_reg    <= 1'b0;
    end else begin
      vsync_d_reg <= din_vsync;
      if (frame_start) begin
        mode_reg <= mode;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Column / row counters (position of the pixel currently on din_data)
  // ---------------------------------------------------------------------------
  logic [CW-1:0] col_cnt_reg;
  logic [CW-1:0] col_cnt_next;
  logic [RW-1:0] row_cnt_reg;
  logic [RW-1:0] row_cnt_next;

  // Next-count logic: frame start clears and wins over an increment; the row
  // counter saturates on the last line.
  always_comb begin
    col_cnt_next = col_cnt_reg;
    row_cnt_next = row_cnt_reg;
    if (frame_start) begin
      col_cnt_next = '0;
      row_cnt_next = '0;
    end else if (din_de) begin
      if (col_cnt_reg == CW'(H_DISP - 1)) begin
        col_cnt_next = '0;
        if (row_cnt_reg != RW'(V_DISP - 1)) begin
          row_cnt_next = row_cnt_reg + RW'(1);
        end
      end else begin
        col_cnt_next = col_cnt_reg + CW'(1);
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_cnt_reg <= '0;
      row_cnt_reg <= '0;
    end else begin
      col_cnt_reg <= col_cnt_next;
      row_cnt_reg <= row_cnt_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Line buffers: a chain of KSIZE-1 one-bit line stores. Reading before
  // writing at the same column gives the pixels of the lines above the
  // current one, so the buffers never need clearing: out-of-frame taps are
  // masked later by the row/column padding.
  // ---------------------------------------------------------------------------
  logic [NLB-1:0]   lb_rd;
  logic [NLB-1:0]   lb_wr;
  logic [KSIZE-1:0] col_in;

  // col_in[r] is the pixel r lines above the current input, same column.
  assign col_in = {lb_rd, pix_in};

  genvar gi;
  generate
    for (gi = 0; gi < NLB; gi++) begin : g_lb
      logic lb_mem [H_DISP];

      if (gi == 0) begin : g_head
        assign lb_wr[gi] = pix_in;
      end else begin : g_chain
        assign lb_wr[gi] = lb_rd[gi-1];
      end

      assign lb_rd[gi] = lb_mem[col_cnt_reg];

      // Line store write, stalled during blanking.
      always_ff @(posedge clk) begin
        if (din_de) begin
          lb_mem[col_cnt_reg] <= lb_wr[gi];
        end
      end
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Stage 1 bookkeeping: position and mode that belong to the window contents
  // ---------------------------------------------------------------------------
  logic [CW-1:0] col_s1_reg;
  logic [RW-1:0] row_s1_reg;
  logic          mode_s1_reg;
  logic          mode_s2_reg;

  // Track the coordinates of the newest window column alongside the window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_s1_reg  <= '0;
      row_s1_reg  <= '0;
      mode_s1_reg <= 1'b0;
      mode_s2_reg <= 1'b0;
    end else begin
      if (din_de) begin
        col_s1_reg <= col_cnt_reg;
        row_s1_reg <= row_cnt_reg;
      end
      mode_s1_reg <= mode_reg;
      mode_s2_reg <= mode_s1_reg;
    end
  end

  // ---------------------------------------------------------------------------
  // Window rows (stage 1), padding and per-row reduction (stage 2)
  // ---------------------------------------------------------------------------
  logic [KSIZE-1:0] row_red;

  generate
    for (gi = 0; gi < KSIZE; gi++) begin : g_row
      logic [KSIZE-1:0] win_reg;
      logic [KSIZE-1:0] tap;
      logic             row_red_reg;

      // Shift one new tap into this window row per accepted pixel; bit k holds
      // the pixel k columns to the left of the newest one.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          win_reg <= '0;
        end else if (din_de) begin
          win_reg <= {win_reg[KSIZE-2:0], col_in[gi]};
        end
      end

      // Taps left of column 0 or above row 0 take the pad value: 1 for erode
      // so borders do not erode, 0 for dilate so borders do not grow.
      always_comb begin
        tap = win_reg;
        for (int k = 0; k < KSIZE; k++) begin
          if ((int'(col_s1_reg) < k) || (int'(row_s1_reg) < gi)) begin
            tap[k] = ~mode_s1_reg;
          end
        end
      end

      // Reduce this row: OR for dilate, AND for erode.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          row_red_reg <= 1'b0;
        end else begin
          row_red_reg <= mode_s1_reg ? |tap : &tap;
        end
      end

      assign row_red[gi] = row_red_reg;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Stage 3: reduction across rows and sync alignment
  // ---------------------------------------------------------------------------
  logic [7:0] dout_data_reg;
  logic [2:0] de_sr_reg;
  logic [2:0] hs_sr_reg;
  logic [2:0] vs_sr_reg;

  // Final reduction across the row results, expanded to an 8-bit pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_data_reg <= 8'h00;
    end else begin
      if (mode_s2_reg ? |row_red : &row_red) begin
        dout_data_reg <= 8'hFF;
      end else begin
        dout_data_reg <= 8'h00;
      end
    end
  end

  // Three-stage delay of the syncs, matching the data pipeline depth.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      de_sr_reg <= '0;
      hs_sr_reg <= '0;
      vs_sr_reg <= '0;
    end else begin
      de_sr_reg <= {de_sr_reg[1:0], din_de};
      hs_sr_reg <= {hs_sr_reg[1:0], din_hsync};
      vs_sr_reg <= {vs_sr_reg[1:0], din_vsync};
    end
  end

  assign dout_de    = de_sr_reg[2];
  assign dout_hsync = hs_sr_reg[2];
  assign dout_vsync = vs_sr_reg[2];
  assign dout_data  = dout_data_reg;

`ifdef MORPH_FG_COUNT_EN
  // ---------------------------------------------------------------------------
  // Foreground pixel counter, reported once per frame at the output vsync edge
  // ---------------------------------------------------------------------------
  localparam int FGW = $clog2(H_DISP*V_DISP+1);

  logic           dvs_d_reg;
  logic [FGW-1:0] fg_cnt_reg;

  // Count foreground output pixels; on the dout_vsync rise publish and clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvs_d_reg    <= 1'b0;
      fg_cnt_reg   <= '0;
      fg_count     <= '0;
      fg_count_vld <= 1'b0;
    end else begin
      dvs_d_reg <= dout_vsync;
      if (dout_vsync && !dvs_d_reg) begin
        fg_count     <= fg_cnt_reg;
        fg_count_vld <= 1'b1;
        fg_cnt_reg   <= '0;
      end else begin
        fg_count_vld <= 1'b0;
        if (dout_de && (dout_data == 8'hFF)) begin
          fg_cnt_reg <= fg_cnt_reg + FGW'(1);
        end
      end
    end
  end
`endif

endmodule
